// File: rtl/force_sweep_scheduler.sv
// force_sweep_scheduler
//   Time-multiplexes one force_calculator over every ordered (object, other)
//   body pair. It fetches positions from a 1-cycle-latency position RAM,
//   accumulates the signed 5.8 pair forces per object body with per-axis
//   saturation, and hands one total per body downstream.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        one-cycle sweep request (honoured only when idle)
//   busy                         sweep in progress
//   done                         one-cycle pulse after the last body's result is taken
//   pos_rd_en / pos_rd_addr      position RAM read strobe and address
//   pos_rd_x / pos_rd_y          position RAM data, valid the cycle after the strobe
//   calc_x_obj/oth, calc_y_obj/oth  registered positions to the calculator
//   calc_x_force / calc_y_force  calculator result (signed 5.8, combinational)
//   out_valid/out_ready          result handshake
//   out_idx, out_fx, out_fy      body index and summed force (signed 5.8)
//   out_sat                      only with FORCE_SWEEP_SAT_FLAG_EN defined: an
//                                accumulator clamped during this body's sweep
module force_sweep_scheduler #(
  parameter int NUM_BODIES = 8,
  parameter int IDX_W      = 3,
  parameter int ACC_W      = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pos_rd_en,
  output logic [IDX_W-1:0]        pos_rd_addr,
  input  logic [6:0]              pos_rd_x,
  input  logic [5:0]              pos_rd_y,
  output logic [6:0]              calc_x_obj,
  output logic [6:0]              calc_x_oth,
  output logic [5:0]              calc_y_obj,
  output logic [5:0]              calc_y_oth,
  input  logic [13:0]             calc_x_force,
  input  logic [13:0]             calc_y_force,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
`ifdef FORCE_SWEEP_SAT_FLAG_EN
  output logic                    out_sat,
`endif
  output logic signed [ACC_W-1:0] out_fx,
  output logic signed [ACC_W-1:0] out_fy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_OBJ  = 3'd1;
  localparam logic [2:0] S_CAP_OBJ = 3'd2;
  localparam logic [2:0] S_RD_OTH  = 3'd3;
  localparam logic [2:0] S_CAP_OTH = 3'd4;
  localparam logic [2:0] S_ACC     = 3'd5;
  localparam logic [2:0] S_EMIT    = 3'd6;

  // oth needs one extra bit so it can reach NUM_BODIES (end of the inner loop)
  localparam logic [IDX_W:0]   OTH_END  = (IDX_W+1)'(NUM_BODIES);
  localparam logic [IDX_W-1:0] OBJ_LAST = IDX_W'(NUM_BODIES-1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [2:0]       state_reg;
  logic [IDX_W-1:0] obj_reg;
  logic [IDX_W:0]   oth_reg;
  logic             done_reg;
  logic             coincident;
  logic             self_pair;
  logic [13:0]      force_in [2];

  assign force_in[0] = calc_x_force;
  assign force_in[1] = calc_y_force;
  assign coincident  = (calc_x_obj == calc_x_oth) && (calc_y_obj == calc_y_oth);
  assign self_pair   = (oth_reg == {1'b0, obj_reg});

  // One saturating accumulator per axis; the clamp value becomes the new
  // accumulator so later pairs continue from the rail.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [ACC_W-1:0] acc_reg;
      logic        [ACC_W:0]   sum;
      logic                    ovf;
      logic signed [ACC_W-1:0] acc_next;

      assign sum = {acc_reg[ACC_W-1], acc_reg}
                 + {{(ACC_W-13){force_in[gi][13]}}, force_in[gi]};
      assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
      assign acc_next = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else if (state_reg == S_CAP_OBJ) begin
          acc_reg <= '0;
        end else if (state_reg == S_ACC && !coincident) begin
          acc_reg <= acc_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      obj_reg    <= '0;
      oth_reg    <= '0;
      done_reg   <= 1'b0;
      calc_x_obj <= '0;
      calc_y_obj <= '0;
      calc_x_oth <= '0;
      calc_y_oth <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            obj_reg   <= '0;
            state_reg <= S_RD_OBJ;
          end
        end
        S_RD_OBJ:  state_reg <= S_CAP_OBJ;
        S_CAP_OBJ: begin
          calc_x_obj <= pos_rd_x;
          calc_y_obj <= pos_rd_y;
          oth_reg    <= '0;
          state_reg  <= S_RD_OTH;
        end
        S_RD_OTH: begin
          if (oth_reg == OTH_END) begin
            state_reg <= S_EMIT;
          end else if (self_pair) begin
            oth_reg <= oth_reg + 1'b1;
          end else begin
            state_reg <= S_CAP_OTH;
          end
        end
        S_CAP_OTH: begin
          calc_x_oth <= pos_rd_x;
          calc_y_oth <= pos_rd_y;
          state_reg  <= S_ACC;
        end
        S_ACC: begin
          oth_reg   <= oth_reg + 1'b1;
          state_reg <= S_RD_OTH;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (obj_reg == OBJ_LAST) begin
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              obj_reg   <= obj_reg + 1'b1;
              state_reg <= S_RD_OBJ;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef FORCE_SWEEP_SAT_FLAG_EN
  logic sat_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_reg <= 1'b0;
    end else if (state_reg == S_CAP_OBJ) begin
      sat_reg <= 1'b0;
    end else if (state_reg == S_ACC && !coincident) begin
      sat_reg <= sat_reg | g_axis[0].ovf | g_axis[1].ovf;
    end
  end
  assign out_sat = sat_reg;
`endif

  // Reads happen in RD_OBJ and in RD_OTH unless the pair is the self pair
  // or the inner loop has run out.
  always_comb begin
    pos_rd_en   = 1'b0;
    pos_rd_addr = '0;
    if (state_reg == S_RD_OBJ) begin
      pos_rd_en   = 1'b1;
      pos_rd_addr = obj_reg;
    end else if (state_reg == S_RD_OTH && oth_reg != OTH_END && !self_pair) begin
      pos_rd_en   = 1'b1;
      pos_rd_addr = oth_reg[IDX_W-1:0];
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign out_valid = (state_reg == S_EMIT);
  assign out_idx   = obj_reg;
  assign out_fx    = g_axis[0].acc_reg;
  assign out_fy    = g_axis[1].acc_reg;

endmodule

// File: tb/tb_force_sweep_scheduler.sv
// Directed bench for force_sweep_scheduler. dut1 uses ACC_W=18, dut2 uses
// ACC_W=14 for the saturation scenario; a mux selects which one is observed.
module tb_force_sweep_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
  logic [13:0] stub_fx = 14'h0100;
  logic [13:0] stub_fy = 14'h3F80;

  logic [6:0] mem_x [8];
  logic [5:0] mem_y [8];

  // dut1 signals
  logic busy1, done1, rd_en1, valid1;
  logic [2:0] addr1, idx1;
  logic [6:0] rx1, cxo1, cxt1;
  logic [5:0] ry1, cyo1, cyt1;
  logic signed [17:0] fx1, fy1;
  // dut2 signals
  logic busy2, done2, rd_en2, valid2;
  logic [2:0] addr2, idx2;
  logic [6:0] rx2, cxo2, cxt2;
  logic [5:0] ry2, cyo2, cyt2;
  logic signed [13:0] fx2, fy2;
  logic sat1, sat2;

  always #5 clk = ~clk;

  force_sweep_scheduler #(.NUM_BODIES(8), .IDX_W(3), .ACC_W(18)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .busy(busy1), .done(done1),
    .pos_rd_en(rd_en1), .pos_rd_addr(addr1), .pos_rd_x(rx1), .pos_rd_y(ry1),
    .calc_x_obj(cxo1), .calc_x_oth(cxt1), .calc_y_obj(cyo1), .calc_y_oth(cyt1),
    .calc_x_force(stub_fx), .calc_y_force(stub_fy),
    .out_valid(valid1), .out_ready(out_ready), .out_idx(idx1),
`ifdef FORCE_SWEEP_SAT_FLAG_EN
    .out_sat(sat1),
`endif
    .out_fx(fx1), .out_fy(fy1));

  force_sweep_scheduler #(.NUM_BODIES(8), .IDX_W(3), .ACC_W(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(busy2), .done(done2),
    .pos_rd_en(rd_en2), .pos_rd_addr(addr2), .pos_rd_x(rx2), .pos_rd_y(ry2),
    .calc_x_obj(cxo2), .calc_x_oth(cxt2), .calc_y_obj(cyo2), .calc_y_oth(cyt2),
    .calc_x_force(stub_fx), .calc_y_force(stub_fy),
    .out_valid(valid2), .out_ready(out_ready), .out_idx(idx2),
`ifdef FORCE_SWEEP_SAT_FLAG_EN
    .out_sat(sat2),
`endif
    .out_fx(fx2), .out_fy(fy2));

`ifndef FORCE_SWEEP_SAT_FLAG_EN
  assign sat1 = 1'b0;
  assign sat2 = 1'b0;
`endif

  // Position RAM model: registered read, one read port per DUT
  always @(posedge clk) begin
    if (rd_en1) begin rx1 <= mem_x[addr1]; ry1 <= mem_y[addr1]; end
    if (rd_en2) begin rx2 <= mem_x[addr2]; ry2 <= mem_y[addr2]; end
  end

  // Observed-DUT mux
  logic m_valid, m_done, m_rd_en, m_busy, m_sat;
  logic [2:0] m_idx;
  logic signed [17:0] m_fx, m_fy;
  assign m_valid = sel ? valid2 : valid1;
  assign m_done  = sel ? done2  : done1;
  assign m_rd_en = sel ? rd_en2 : rd_en1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_sat   = sel ? sat2   : sat1;
  assign m_idx   = sel ? idx2   : idx1;
  assign m_fx    = sel ? {{4{fx2[13]}}, fx2} : fx1;
  assign m_fy    = sel ? {{4{fy2[13]}}, fy2} : fy1;

  int done1_cnt = 0;
  int done2_cnt = 0;
  always @(negedge clk) begin
    if (done1) done1_cnt++;
    if (done2) done2_cnt++;
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Results gathered by collect_sweep (no checking in there)
  int r_idx [8];
  int r_fx [8];
  int r_fy [8];
  bit r_sat [8];
  int n_res, lat, stall_seen;
  bit timeout, done_next, stall_ok, stall_rd;

  task automatic init_mem();
    for (int i = 0; i < 8; i++) begin
      mem_x[i] = 7'(10 * i + 3);
      mem_y[i] = 6'(5 * i + 1);
    end
  endtask

  // Starts a sweep on the selected DUT and records every handshaked result.
  task automatic collect_sweep(input int stall_body, input bit hold_start);
    int cyc;
    bit last;
    logic signed [17:0] snap_fx, snap_fy;
    cyc = 0; last = 0; n_res = 0; lat = -1; timeout = 1; done_next = 0;
    stall_seen = 0; stall_ok = 1; stall_rd = 0; snap_fx = '0; snap_fy = '0;
    start = 1'b1; out_ready = 1'b1;
    while (cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (last) begin done_next = m_done; timeout = 0; break; end
      if (!hold_start) start = 1'b0;
      if (m_valid) begin
        if (lat < 0) lat = cyc;
        if (int'(m_idx) == stall_body && stall_seen < 10) begin
          if (stall_seen == 0) begin
            snap_fx = m_fx; snap_fy = m_fy;
          end else if (m_fx !== snap_fx || m_fy !== snap_fy) begin
            stall_ok = 0;
          end
          if (m_rd_en) stall_rd = 1;
          out_ready = 1'b0;
          stall_seen++;
        end else begin
          out_ready = 1'b1;
          if (n_res < 8) begin
            r_idx[n_res] = int'(m_idx); r_fx[n_res] = int'(m_fx);
            r_fy[n_res] = int'(m_fy); r_sat[n_res] = m_sat;
            $display("[TB] result idx=%0d fx=%0d fy=%0d sat=%0b", m_idx, m_fx, m_fy, m_sat);
          end
          n_res++;
          if (n_res == 8) begin last = 1; start = 1'b0; end
        end
      end else begin
        if (stall_seen > 0 && stall_seen < 10) stall_ok = 0;
        if (stall_seen > 0 && stall_seen < 10 && m_rd_en) stall_rd = 1;
        out_ready = 1'b1;
      end
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy1, done1, valid1, rd_en1, idx1, addr1} !== 10'd0 || fx1 !== 18'sd0 || fy1 !== 18'sd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%0b done=%0b valid=%0b rd_en=%0b idx=%0d addr=%0d fx=%0d fy=%0d, required all 0",
               busy1, done1, valid1, rd_en1, idx1, addr1, fx1, fy1);
    end
    tests_run++;
    if ({cxo1, cxt1, cyo1, cyt1} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_calc_regs: %h, required 0", {cxo1, cxt1, cyo1, cyt1});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_sweep();
    int d0;
    d0 = done1_cnt;
    sel = 1'b0; stub_fx = 14'h0100; stub_fy = 14'h3F80;
    collect_sweep(-1, 1'b0);
    tests_run++;
    if (timeout !== 1'b0 || n_res !== 8) begin
      tests_failed++; $display("FAIL full_timeout: results=%0d, required 8", n_res);
    end
    tests_run++;
    if (lat !== 26) begin
      tests_failed++; $display("FAIL full_first_valid_latency: got %0d, required 26", lat);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (r_idx[i] !== i || r_fx[i] !== 1792 || r_fy[i] !== -896 || r_sat[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_result[%0d]: idx=%0d fx=%0d fy=%0d sat=%0b, required idx=%0d fx=1792 fy=-896 sat=0",
                 i, r_idx[i], r_fx[i], r_fy[i], r_sat[i], i);
      end
    end
    tests_run++;
    if (done_next !== 1'b1) begin
      tests_failed++; $display("FAIL full_done_timing: done=%0b after last handshake, required 1", done_next);
    end
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (done1_cnt - d0 !== 1 || busy1 !== 1'b0) begin
      tests_failed++; $display("FAIL full_done_count: %0d pulses busy=%0b, required 1 pulse busy=0", done1_cnt - d0, busy1);
    end
  endtask

  task automatic test_coincident();
    int efx, efy;
    mem_x[2] = 7'd40; mem_y[2] = 6'd20;
    mem_x[5] = 7'd40; mem_y[5] = 6'd20;
    sel = 1'b0; stub_fx = 14'h0100; stub_fy = 14'h3F80;
    collect_sweep(-1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      efx = (i == 2 || i == 5) ? 1536 : 1792;
      efy = (i == 2 || i == 5) ? -768 : -896;
      tests_run++;
      if (timeout !== 1'b0 || r_idx[i] !== i || r_fx[i] !== efx || r_fy[i] !== efy) begin
        tests_failed++;
        $display("FAIL coincident_result[%0d]: idx=%0d fx=%0d fy=%0d timeout=%0b, required fx=%0d fy=%0d",
                 i, r_idx[i], r_fx[i], r_fy[i], timeout, efx, efy);
      end
    end
    init_mem();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    sel = 1'b1; stub_fx = 14'h1FFF; stub_fy = 14'h2000;
    collect_sweep(-1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (timeout !== 1'b0 || r_idx[i] !== i || r_fx[i] !== 8191 || r_fy[i] !== -8192) begin
        tests_failed++;
        $display("FAIL sat_result[%0d]: idx=%0d fx=%0d fy=%0d, required fx=8191 fy=-8192", i, r_idx[i], r_fx[i], r_fy[i]);
      end
`ifdef FORCE_SWEEP_SAT_FLAG_EN
      tests_run++;
      if (r_sat[i] !== 1'b1) begin
        tests_failed++; $display("FAIL sat_flag[%0d]: got %0b, required 1", i, r_sat[i]);
      end
`endif
    end
    repeat (2) @(posedge clk); #1;
    sel = 1'b0; stub_fx = 14'h0100; stub_fy = 14'h3F80;
  endtask

  task automatic test_backpressure();
    sel = 1'b0; stub_fx = 14'h0100; stub_fy = 14'h3F80;
    collect_sweep(3, 1'b0);
    tests_run++;
    if (stall_seen !== 10 || stall_ok !== 1'b1 || stall_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_hold: stalled=%0d stable=%0b rd_en_seen=%0b, required 10/1/0", stall_seen, stall_ok, stall_rd);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (timeout !== 1'b0 || r_idx[i] !== i || r_fx[i] !== 1792 || r_fy[i] !== -896) begin
        tests_failed++;
        $display("FAIL backpressure_result[%0d]: idx=%0d fx=%0d fy=%0d, required idx=%0d fx=1792 fy=-896", i, r_idx[i], r_fx[i], r_fy[i], i);
      end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, d0;
    bit found;
    sel = 1'b0; d0 = done1_cnt; found = 0; cyc = 0;
    start = 1'b1;
    while (cyc < 500) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      if (idx1 == 3'd4 && rd_en1 && addr1 != 3'd4) begin found = 1; break; end
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL midreset_reach_body4: not reached in %0d cycles", cyc);
    end
    @(posedge clk); #2;   // now inside body 4's CAP_OTH
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy1, done1, valid1, rd_en1, idx1} !== 7'd0 || fx1 !== 18'sd0 || fy1 !== 18'sd0 || {cxo1, cxt1, cyo1, cyt1} !== 26'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: busy=%0b valid=%0b rd_en=%0b idx=%0d fx=%0d fy=%0d, required all 0",
               busy1, valid1, rd_en1, idx1, fx1, fy1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (done1_cnt !== d0 || busy1 !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_no_done: pulses=%0d busy=%0b, required 0 and 0", done1_cnt - d0, busy1);
    end
    collect_sweep(-1, 1'b0);
    tests_run++;
    if (timeout !== 1'b0 || lat !== 26 || done_next !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_resweep: timeout=%0b latency=%0d done=%0b, required 0/26/1", timeout, lat, done_next);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (r_idx[i] !== i || r_fx[i] !== 1792 || r_fy[i] !== -896) begin
        tests_failed++;
        $display("FAIL midreset_result[%0d]: idx=%0d fx=%0d fy=%0d, required idx=%0d fx=1792 fy=-896", i, r_idx[i], r_fx[i], r_fy[i], i);
      end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int d0;
    sel = 1'b0; d0 = done1_cnt;
    collect_sweep(-1, 1'b1);
    tests_run++;
    if (timeout !== 1'b0 || lat !== 26) begin
      tests_failed++; $display("FAIL spam_latency: timeout=%0b latency=%0d, required 0/26", timeout, lat);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (r_idx[i] !== i || r_fx[i] !== 1792 || r_fy[i] !== -896) begin
        tests_failed++;
        $display("FAIL spam_result[%0d]: idx=%0d fx=%0d fy=%0d, required idx=%0d fx=1792 fy=-896", i, r_idx[i], r_fx[i], r_fy[i], i);
      end
    end
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (done1_cnt - d0 !== 1 || busy1 !== 1'b0) begin
      tests_failed++; $display("FAIL spam_done_count: %0d pulses busy=%0b, required 1 pulse busy=0", done1_cnt - d0, busy1);
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_full_sweep();
    test_coincident();
    test_saturation();
    test_backpressure();
    test_reset_mid_sweep();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
